aes_req_scheduler: RTL and testbench
====================================

Name: aes_req_scheduler

Overview:
Sequences and shares one combinational AES encrypt/decrypt datapath between two requesters: an encrypt port and a decrypt port. Operands and key are registered into the datapath, and the block waits a fixed settle time, treating the datapath as a multicycle path. The result is then captured and presented on a single valid/ready result port tagged with its operation. Sits between the host-side request logic and the AES datapath instance; one operation is in flight at a time.

Parameters:
SETTLE_CYCLES, 4, cycles from operand register update to result capture; legal range 1..15.
CNT_W, 4, settle counter width; must hold SETTLE_CYCLES.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
enc_valid  input  1  encrypt request valid.
enc_ready  output  1  encrypt request accepted this cycle.
enc_data  input  128  plaintext to encrypt.
enc_key  input  128  key for encrypt request.
dec_valid  input  1  decrypt request valid.
dec_ready  output  1  decrypt request accepted this cycle.
dec_data  input  128  ciphertext to decrypt.
dec_key  input  128  key for decrypt request.
aes_plain_in  output  128  registered plaintext to datapath.
aes_cipher_in  output  128  registered ciphertext to datapath.
aes_key  output  128  registered key to datapath.
aes_cipher_out  input  128  datapath encrypt result.
aes_plain_out  input  128  datapath decrypt result.
res_valid  output  1  result valid.
res_ready  input  1  result consumer ready.
res_data  output  128  captured result.
res_is_dec  output  1  1 = res_data is a decrypt result, 0 = encrypt.

Behaviour:
- Reset (async, any time):
  - state=IDLE; all registered outputs 0, i.e. aes_plain_in, aes_cipher_in, aes_key, res_data, res_is_dec, res_valid.
  - last_dec=1, so encrypt wins the first tie.
  - An in-flight op is abandoned; no res_valid follows.
- FSM states IDLE, BUSY, DONE.
- IDLE:
  - Grant is combinational. Only enc_valid → enc. Only dec_valid → dec. Both → the side other than last_dec.
  - Only the granted side's ready=1. Both readies are 0 outside IDLE and 0 in IDLE with no valid.
  - A transfer is valid&&ready.
  - On transfer for enc: aes_plain_in<=enc_data, aes_key<=enc_key, op<=0, last_dec<=0.
  - On transfer for dec: aes_cipher_in<=dec_data, aes_key<=dec_key, op<=1, last_dec<=1.
  - The non-selected operand register holds its value.
  - On transfer: cnt<=SETTLE_CYCLES-1, state<=BUSY.
- BUSY:
  - cnt decrements each cycle.
  - At cnt==0: res_data<=(op ? aes_plain_out : aes_cipher_out), res_is_dec<=op, res_valid<=1, state<=DONE.
  - Capture edge is exactly SETTLE_CYCLES edges after the accept edge.
- DONE:
  - res_valid, res_data and res_is_dec are held stable until res_valid&&res_ready.
  - On that edge: res_valid<=0, state<=IDLE.
  - No request is accepted in the same cycle as the result handshake.
- Min accept-to-accept period is SETTLE_CYCLES+2 cycles with res_ready tied high.
- Requesters must hold valid and data until ready. Input changes after acceptance have no effect.
- A requester deasserting valid before grant is legal; no transfer occurs.
- Back-pressure: res_ready low holds DONE indefinitely; no requests are accepted.
- Round-robin guarantees that, under continuous contention, enc and dec alternate strictly.

Test Plan:
- Encrypt with FIPS-197 vector:
  - Stimulus: enc_data=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f, res_ready=1.
  - Response: enc_ready on cycle 0; res_valid exactly SETTLE_CYCLES edges later; res_data=69c4e0d86a7b0430d8cdb78070b4c55a; res_is_dec=0.
- Decrypt of 69c4e0d86a7b0430d8cdb78070b4c55a with the same key → res_data=00112233445566778899aabbccddeeff, res_is_dec=1.
- Contention: both valid continuously, 4 ops → grant order enc, dec, enc, dec; each period SETTLE_CYCLES+2; enc_ready and dec_ready never both 1.
- Back-pressure: res_ready=0 for 10 cycles after res_valid → res_data stable, res_valid held, enc_ready/dec_ready stay 0; res_ready=1 → res_valid drops next edge.
- Reset mid-BUSY: assert rst at cnt=2 → immediately all outputs 0; no res_valid after release; first tie after reset goes to enc.
- Input perturbation: change enc_data and enc_key to all-ones during BUSY → result still matches the operands captured at acceptance.

Source files
------------

// File: rtl/aes_req_scheduler.sv
// Round-robin scheduler for one shared combinational AES encrypt/decrypt datapath.
// Operands are registered, the result is captured after a fixed settle time and then held until accepted.
module aes_req_scheduler #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enc_valid,
  output logic         enc_ready,
  input  logic [127:0] enc_data,
  input  logic [127:0] enc_key,
  input  logic         dec_valid,
  output logic         dec_ready,
  input  logic [127:0] dec_data,
  input  logic [127:0] dec_key,
  output logic [127:0] aes_plain_in,
  output logic [127:0] aes_cipher_in,
  output logic [127:0] aes_key,
  input  logic [127:0] aes_cipher_out,
  input  logic [127:0] aes_plain_out,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [127:0] res_data,
  output logic         res_is_dec
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             op_reg;
  logic             last_dec_reg;
  logic             grant_enc;
  logic             grant_dec;

  // On a tie the side that did not win last time gets the grant.
  always_comb begin
    grant_enc = (state_reg == IDLE) && enc_valid && (!dec_valid || last_dec_reg);
    grant_dec = (state_reg == IDLE) && dec_valid && (!enc_valid || !last_dec_reg);
  end

  assign enc_ready = grant_enc;
  assign dec_ready = grant_dec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      op_reg        <= 1'b0;
      last_dec_reg  <= 1'b1;
      aes_plain_in  <= '0;
      aes_cipher_in <= '0;
      aes_key       <= '0;
      res_data      <= '0;
      res_is_dec    <= 1'b0;
      res_valid     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_enc) begin
            aes_plain_in <= enc_data;
            aes_key      <= enc_key;
            op_reg       <= 1'b0;
            last_dec_reg <= 1'b0;
            cnt_reg      <= CNT_INIT;
            state_reg    <= BUSY;
          end else if (grant_dec) begin
            aes_cipher_in <= dec_data;
            aes_key       <= dec_key;
            op_reg        <= 1'b1;
            last_dec_reg  <= 1'b1;
            cnt_reg       <= CNT_INIT;
            state_reg     <= BUSY;
          end
        end
        // The datapath is a multicycle path: sample only once the count has run out.
        BUSY: begin
          if (cnt_reg == '0) begin
            res_data   <= op_reg ? aes_plain_out : aes_cipher_out;
            res_is_dec <= op_reg;
            res_valid  <= 1'b1;
            state_reg  <= DONE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_req_scheduler.sv
// Bench for aes_req_scheduler: directed scenarios plus random traffic against a transaction-level scoreboard.
// The AES datapath is replaced by a stand-in that returns the FIPS-197 vector for its known operands.
module tb_aes_req_scheduler;
  localparam int S = 4;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 0, rst = 1;
  logic enc_valid = 0, dec_valid = 0, res_ready = 1;
  logic [127:0] enc_data = '0, enc_key = '0, dec_data = '0, dec_key = '0;
  logic enc_ready, dec_ready, res_valid, res_is_dec;
  logic [127:0] aes_plain_in, aes_cipher_in, aes_key, aes_cipher_out, aes_plain_out, res_data;

  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [127:0] dp_enc(input logic [127:0] p, input logic [127:0] k);
    if (p == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
    return (p ^ k) + {k[63:0], k[127:64]};
  endfunction

  function automatic logic [127:0] dp_dec(input logic [127:0] c, input logic [127:0] k);
    if (c == FIPS_CT && k == FIPS_KEY) return FIPS_PT;
    return (c - {k[63:0], k[127:64]}) ^ k;
  endfunction

  assign aes_cipher_out = dp_enc(aes_plain_in, aes_key);
  assign aes_plain_out  = dp_dec(aes_cipher_in, aes_key);

  aes_req_scheduler #(.SETTLE_CYCLES(S), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .enc_valid(enc_valid), .enc_ready(enc_ready), .enc_data(enc_data), .enc_key(enc_key),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_data(dec_data), .dec_key(dec_key),
    .aes_plain_in(aes_plain_in), .aes_cipher_in(aes_cipher_in), .aes_key(aes_key),
    .aes_cipher_out(aes_cipher_out), .aes_plain_out(aes_plain_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_is_dec(res_is_dec)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: one outstanding op, its expected result and the cycle it was accepted.
  int          cyc = 0;
  bit          m_inflight = 0, m_op = 0, m_last_dec = 1;
  logic [127:0] m_exp = '0;
  int          m_acc = 0;

  always @(negedge clk) begin
    bit vis, ge, gd;
    cyc++;
    if (rst) begin
      check("rst_ctl", {126'd0, res_valid, res_is_dec}, '0);
      check("rst_key", aes_key, '0);
      check("rst_pt", aes_plain_in, '0);
      check("rst_ct", aes_cipher_in, '0);
      check("rst_res", res_data, '0);
      m_inflight = 0;
      m_last_dec = 1;
    end else begin
      vis = m_inflight && (cyc >= m_acc + S + 1);
      check("res_valid", {127'd0, res_valid}, {127'd0, vis});
      if (vis) begin
        check("res_data", res_data, m_exp);
        check("res_is_dec", {127'd0, res_is_dec}, {127'd0, m_op});
      end
      ge = !m_inflight && enc_valid && (!dec_valid || m_last_dec);
      gd = !m_inflight && dec_valid && (!enc_valid || !m_last_dec);
      check("ready", {126'd0, enc_ready, dec_ready}, {126'd0, ge, gd});
      if (vis && res_ready) m_inflight = 0;
      if (ge || gd) begin
        m_inflight = 1;
        m_op       = gd;
        m_exp      = gd ? dp_dec(dec_data, dec_key) : dp_enc(enc_data, enc_key);
        m_acc      = cyc;
        m_last_dec = gd;
      end
    end
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  // Called one tick after an active edge; returns one tick after the accepting edge.
  task automatic send(input bit is_dec, input logic [127:0] d, input logic [127:0] k, output int acc);
    bit got = 0;
    acc = 0;
    if (is_dec) begin dec_valid = 1; dec_data = d; dec_key = k; end
    else        begin enc_valid = 1; enc_data = d; enc_key = k; end
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (is_dec ? dec_ready : enc_ready) begin got = 1; acc = $time / 10; end
    end
    check("send_accept", {127'd0, got}, 128'd1);
    align();
    enc_valid = 0;
    dec_valid = 0;
  endtask

  task automatic wait_res(output int c);
    bit got = 0;
    c = 0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (res_valid) begin got = 1; c = $time / 10; end
    end
    check("res_timeout", {127'd0, got}, 128'd1);
  endtask

  initial begin
    int a, r, last_c, side;
    logic [127:0] held;
    bit ea, da, seen;

    repeat (3) @(negedge clk);
    align();
    rst = 0;

    // FIPS encrypt, operands perturbed while the op is in flight
    send(0, FIPS_PT, FIPS_KEY, a);
    enc_data = '1;
    enc_key  = '1;
    wait_res(r);
    check("fips_enc", res_data, FIPS_CT);
    check("fips_enc_tag", {127'd0, res_is_dec}, 128'd0);
    check("fips_latency", 128'(r - a), 128'(S + 1));
    align();

    send(1, FIPS_CT, FIPS_KEY, a);
    wait_res(r);
    check("fips_dec", res_data, FIPS_PT);
    check("fips_dec_tag", {127'd0, res_is_dec}, 128'd1);
    align();

    // Continuous contention: strict alternation, enc first after a decrypt
    enc_valid = 1; enc_data = {$urandom, $urandom, $urandom, $urandom}; enc_key = {$urandom, $urandom, $urandom, $urandom};
    dec_valid = 1; dec_data = {$urandom, $urandom, $urandom, $urandom}; dec_key = {$urandom, $urandom, $urandom, $urandom};
    last_c = 0;
    for (int k = 0; k < 4; k++) begin
      seen = 0;
      for (int i = 0; i < 64 && !seen; i++) begin
        @(negedge clk);
        if (enc_ready || dec_ready) begin
          seen = 1;
          check("both_ready", {127'd0, enc_ready & dec_ready}, 128'd0);
          side = dec_ready ? 1 : 0;
          check("rr_order", 128'(side), 128'(k % 2));
          if (k > 0) check("rr_period", 128'($time / 10 - last_c), 128'(S + 2));
          last_c = $time / 10;
        end
      end
      check("rr_grant", {127'd0, seen}, 128'd1);
    end
    align();
    enc_valid = 0;
    dec_valid = 0;
    wait_res(r);
    align();

    // Back-pressure with both requesters waiting
    res_ready = 0;
    send(0, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, a);
    wait_res(r);
    held = res_data;
    align();
    enc_valid = 1;
    dec_valid = 1;
    repeat (10) begin
      @(negedge clk);
      check("bp_valid", {127'd0, res_valid}, 128'd1);
      check("bp_data", res_data, held);
      check("bp_ready", {126'd0, enc_ready, dec_ready}, 128'd0);
    end
    align();
    res_ready = 1;
    enc_valid = 0;
    dec_valid = 0;
    @(negedge clk);
    @(negedge clk);
    check("bp_release", {127'd0, res_valid}, 128'd0);
    align();

    // Reset while BUSY with two settle cycles left
    send(0, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, a);
    align();
    rst = 1;
    #1;
    check("arst_ctl", {126'd0, res_valid, res_is_dec}, '0);
    check("arst_key", aes_key, '0);
    check("arst_pt", aes_plain_in, '0);
    check("arst_ct", aes_cipher_in, '0);
    check("arst_res", res_data, '0);
    align();
    rst = 0;
    repeat (12) begin
      @(negedge clk);
      check("arst_no_res", {127'd0, res_valid}, 128'd0);
    end
    align();
    enc_valid = 1;
    dec_valid = 1;
    @(negedge clk);
    check("arst_tie", {126'd0, enc_ready, dec_ready}, 128'b10);
    align();
    enc_valid = 0;
    dec_valid = 0;
    wait_res(r);
    align();

    // Random traffic; requesters hold until accepted but may withdraw early
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      ea = enc_valid && enc_ready;
      da = dec_valid && dec_ready;
      align();
      if (enc_valid && !ea && $urandom_range(7) == 0) enc_valid = 0;
      else if (ea || !enc_valid) begin
        enc_valid = 1'($urandom_range(1));
        enc_data  = {$urandom, $urandom, $urandom, $urandom};
        enc_key   = {$urandom, $urandom, $urandom, $urandom};
      end
      if (dec_valid && !da && $urandom_range(7) == 0) dec_valid = 0;
      else if (da || !dec_valid) begin
        dec_valid = 1'($urandom_range(1));
        dec_data  = {$urandom, $urandom, $urandom, $urandom};
        dec_key   = {$urandom, $urandom, $urandom, $urandom};
      end
      res_ready = ($urandom_range(3) != 0);
    end
    enc_valid = 0;
    dec_valid = 0;
    res_ready = 1;
    repeat (2 * S + 6) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
